rv_decode_stage: RTL

Parametrised, handshaked instruction-decode stage for the rv32i core. It sits between the fetch stage and the execute stage. Each accepted instruction word is fully decoded into register addresses, function fields, a sign-extended immediate, control flags and an illegal-instruction flag. A 2-entry skid buffer sustains one instruction per cycle under execute-stage back-pressure, and the stage supports pipeline flush.

---
 rtl/rv_decode_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rv_decode_stage.sv
// rv32i instruction-decode stage: combinational decode into an output register
// backed by a one-entry skid register, with flush and illegal-encoding detection.
module rv_decode_stage #(
    parameter int XLEN          = 32,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [4:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      f3_o,
    output logic [6:0]      f7_o,
    output logic [XLEN-1:0] imm_o,
    output logic            use_imm_o,
    output logic            reg_we_o,
    output logic            illegal_o
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_we;
        logic            illegal;
    } dec_t;

    // Fields are extracted by format even for illegal words; only reg_we is suppressed.
    function automatic dec_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        dec_t               d;
        logic signed [31:0] imm32;
        logic               known;
        logic               bad;
        logic               writes;
        logic [2:0]         f3;
        logic [6:0]         f7;
        f3       = ins[14:12];
        f7       = ins[31:25];
        d        = '0;
        d.pc     = pc;
        d.opcode = ins[6:2];
        imm32    = '0;
        known    = 1'b1;
        bad      = 1'b0;
        writes   = 1'b0;
        case (ins[6:2])
            OPC_OP: begin
                d.rd   = ins[11:7];
                d.rs1  = ins[19:15];
                d.rs2  = ins[24:20];
                d.f3   = f3;
                d.f7   = f7;
                writes = 1'b1;
                bad    = !(f7 == 7'h00 || f7 == 7'h20) ||
                         (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
                d.rd      = ins[11:7];
                d.rs1     = ins[19:15];
                d.f3      = f3;
                imm32     = {{20{ins[31]}}, ins[31:20]};
                d.use_imm = 1'b1;
                writes    = (ins[6:2] != OPC_MISC_MEM);
                if (ins[6:2] == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
                    d.f7 = f7;
                end
                case (ins[6:2])
                    OPC_OP_IMM: bad = (f3 == 3'b001 && f7 != 7'h00) ||
                                      (f3 == 3'b101 && !(f7 == 7'h00 || f7 == 7'h20));
                    OPC_LOAD:   bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                    OPC_JALR:   bad = (f3 != 3'b000);
                    default:    bad = 1'b0;
                endcase
            end
            OPC_STORE: begin
                d.rs1     = ins[19:15];
                d.rs2     = ins[24:20];
                d.f3      = f3;
                imm32     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.use_imm = 1'b1;
                bad       = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                d.rs1 = ins[19:15];
                d.rs2 = ins[24:20];
                d.f3  = f3;
                imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                bad   = (f3 == 3'b010 || f3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: begin
                d.rd      = ins[11:7];
                imm32     = {ins[31:12], 12'h000};
                d.use_imm = 1'b1;
                writes    = 1'b1;
            end
            OPC_JAL: begin
                d.rd   = ins[11:7];
                imm32  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                writes = 1'b1;
            end
            default: known = 1'b0;
        endcase
        d.illegal = (ins[1:0] != 2'b11) || !known || (CHECK_ILLEGAL && bad);
        d.imm     = XLEN'(imm32);
        d.reg_we  = writes && (d.rd != 5'd0) && !d.illegal;
        return d;
    endfunction

    dec_t dec;
    dec_t out_p0;
    dec_t skid_p0;
    logic vld_p0;
    logic skid_vld_p0;
    logic in_fire;
    logic out_fire;

    always_comb begin
        dec = decode(if_instr_i, if_pc_i);
    end

    assign if_ready_o = !skid_vld_p0;
    assign in_fire    = if_valid_i && !skid_vld_p0;
    assign out_fire   = vld_p0 && ex_ready_i;

    // Stage p0: OUT register with SKID behind it; SKID always drains into OUT first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0      <= 1'b0;
            skid_vld_p0 <= 1'b0;
            out_p0      <= '0;
            skid_p0     <= '0;
        end else if (flush_i) begin
            vld_p0      <= 1'b0;
            skid_vld_p0 <= 1'b0;
        end else if (out_fire) begin
            if (skid_vld_p0) begin
                out_p0      <= skid_p0;
                skid_vld_p0 <= 1'b0;
            end else if (in_fire) begin
                out_p0 <= dec;
            end else begin
                vld_p0 <= 1'b0;
            end
        end else if (in_fire) begin
            if (vld_p0) begin
                skid_p0     <= dec;
                skid_vld_p0 <= 1'b1;
            end else begin
                out_p0 <= dec;
                vld_p0 <= 1'b1;
            end
        end
    end

    assign ex_valid_o = vld_p0;
    assign ex_pc_o    = out_p0.pc;
    assign opcode_o   = out_p0.opcode;
    assign rd_o       = out_p0.rd;
    assign rs1_o      = out_p0.rs1;
    assign rs2_o      = out_p0.rs2;
    assign f3_o       = out_p0.f3;
    assign f7_o       = out_p0.f7;
    assign imm_o      = out_p0.imm;
    assign use_imm_o  = out_p0.use_imm;
    assign reg_we_o   = out_p0.reg_we;
    assign illegal_o  = out_p0.illegal;

endmodule
